router_pkt_tx: RTL
==================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port ld_en  input  1  writes ld_data into payload buffer.
REQ-004 SHALL have port ld_data  input  8  payload byte to load.
REQ-005 SHALL have port start  input  1  single-cycle request to send the loaded packet.
REQ-006 SHALL have port dest_addr  input  2  destination port 0..2, sampled with start.
REQ-007 SHALL have port inj_err  input  1  parity-corruption request, sampled with start.
REQ-008 SHALL have port busy  input  1  router busy; source holds while high.
REQ-009 SHALL have port error  input  1  router parity-error indication.
REQ-010 SHALL have port pkt_valid  output  1  high during header and payload bytes.
REQ-011 SHALL have port data_out  output  8  byte driven to the router.
REQ-012 SHALL have port ld_full  output  1  buffer holds 63 bytes.
REQ-013 SHALL have port tx_active  output  1  high from header until return to IDLE.
REQ-014 SHALL have port tx_done  output  1  one-cycle pulse at packet completion.
REQ-015 SHALL have port pkt_err  output  1  router flagged error on last packet.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 SHALL hold payload in a 63x8 buffer with 6-bit count; ld_en accepted only in IDLE and when count<63, else ignored.
REQ-018 SHALL implement states IDLE, HEADER, PAYLOAD, PARITY, CHECK.
REQ-019 IDLE: start with count>=1 and dest_addr!=3 SHALL latch addr/len/inj_err, clear pkt_err, enter HEADER next cycle; otherwise start SHALL pulse cfg_err next cycle, no state change.
REQ-020 HEADER SHALL drive pkt_valid=1, data_out={len[5:0],addr[1:0]}; advance to PAYLOAD on a cycle with busy=0.
REQ-021 PAYLOAD SHALL drive pkt_valid=1, data_out=buffer[idx], idx from 0; idx increments on busy=0; after byte len-1 accepted go to PARITY.
REQ-022 PARITY SHALL drive pkt_valid=0, data_out=XOR of header and all payload bytes; advance to CHECK on busy=0.
REQ-023 CHECK SHALL last exactly 2 cycles; error=1 in either cycle SHALL set pkt_err (held until next accepted start); exit pulses tx_done, clears count, returns IDLE.
REQ-024 While busy=1 in HEADER/PAYLOAD/PARITY, pkt_valid and data_out SHALL remain stable.
REQ-025 Parity SHALL be accumulated incrementally as bytes are accepted, not recomputed.
REQ-026 In IDLE and CHECK pkt_valid=0, data_out=0x00; tx_active=1 in HEADER..CHECK.
REQ-027 start, ld_en while tx_active SHALL be ignored (no cfg_err).

Reset
REQ-028 rstn=0 SHALL immediately force IDLE, count=0, idx=0, parity=0, and all outputs 0, including mid-packet; the aborted packet SHALL NOT resume.

Configuration
REQ-029 With macro ROUTER_TX_PARITY_INJ_EN defined, a packet started with inj_err=1 SHALL send the bitwise inverse of the correct parity byte.
REQ-030 Without ROUTER_TX_PARITY_INJ_EN, inj_err SHALL be ignored and parity always correct; port remains present.

Verification
REQ-031 Load 0x11,0x22,0x33; start addr=1, busy=0 -> bytes 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0; tx_done 2 cycles later.
REQ-032 Same packet, busy=1 for 3 cycles during byte 0x22 -> data_out holds 0x22, pkt_valid=1 for 4 cycles, sequence otherwise unchanged.
REQ-033 start with count=0, and start with dest_addr=3 -> cfg_err pulse each, pkt_valid stays 0.
REQ-034 Load 64 bytes -> ld_full=1 after 63rd, 64th ignored, header=0xFC|addr.
REQ-035 rstn low during PAYLOAD byte 2 -> outputs 0 asynchronously, IDLE, count=0 after release.
REQ-036 Macro defined, inj_err=1, payload 0x11,0x22,0x33 addr 1 -> parity byte 0xF2; error driven 1 in CHECK -> pkt_err=1.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet source for the router: buffers up to 63 payload bytes, then sends header, payload and parity.
// Optional feature macro: ROUTER_TX_PARITY_INJ_EN (inj_err inverts the parity byte of that packet).
module router_pkt_tx (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ld_en,
    input  logic [7:0] ld_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic       inj_err,
    input  logic       busy,
    input  logic       error,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       ld_full,
    output logic       tx_active,
    output logic       tx_done,
    output logic       pkt_err,
    output logic       cfg_err
);

    // state     | meaning
    // S_IDLE    | loading payload, waiting for start
    // S_HEADER  | driving {len, addr}
    // S_PAYLOAD | driving buffer[idx]
    // S_PARITY  | driving accumulated parity, pkt_valid low
    // S_CHECK   | two cycles watching router error
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_CHECK
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pbuf [0:62];
    logic [5:0] count_q;
    logic [5:0] idx_q;
    logic [5:0] len_q;
    logic [1:0] addr_q;
    logic [7:0] parity_q;
    logic       chk_q;
    logic       start_ok;
    logic       load_ok;
    logic       last_byte;
    logic [7:0] header_byte;
    logic [7:0] parity_byte;

    assign start_ok    = start && (count_q != 6'd0) && (dest_addr != 2'd3);
    assign load_ok     = ld_en && (state_q == S_IDLE) && (count_q != 6'd63);
    assign last_byte   = (idx_q == len_q - 6'd1);
    assign header_byte = {len_q, addr_q};
    assign ld_full     = (count_q == 6'd63);

`ifdef ROUTER_TX_PARITY_INJ_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            inv_q <= 1'b0;
        else if (state_q == S_IDLE && start_ok)
            inv_q <= inj_err;
    end

    assign parity_byte = inv_q ? ~parity_q : parity_q;
`else
    logic unused_inj;

    assign unused_inj  = inj_err;
    assign parity_byte = parity_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pkt_valid = 1'b0;
        data_out  = 8'h00;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok)
                    state_d = S_HEADER;
            end
            S_HEADER: begin
                pkt_valid = 1'b1;
                data_out  = header_byte;
                tx_active = 1'b1;
                if (!busy)
                    state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = pbuf[idx_q];
                tx_active = 1'b1;
                if (!busy && last_byte)
                    state_d = S_PARITY;
            end
            S_PARITY: begin
                data_out  = parity_byte;
                tx_active = 1'b1;
                if (!busy)
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                tx_active = 1'b1;
                if (chk_q) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payload storage needs no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (load_ok)
            pbuf[count_q] <= ld_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= 6'd0;
            idx_q    <= 6'd0;
            len_q    <= 6'd0;
            addr_q   <= 2'd0;
            parity_q <= 8'h00;
            chk_q    <= 1'b0;
            pkt_err  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_ok)
                        count_q <= count_q + 6'd1;
                    if (start) begin
                        if (start_ok) begin
                            addr_q   <= dest_addr;
                            len_q    <= count_q;
                            idx_q    <= 6'd0;
                            parity_q <= 8'h00;
                            chk_q    <= 1'b0;
                            pkt_err  <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy)
                        parity_q <= header_byte;
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        parity_q <= parity_q ^ pbuf[idx_q];
                        idx_q    <= idx_q + 6'd1;
                    end
                end
                S_CHECK: begin
                    if (error)
                        pkt_err <= 1'b1;
                    chk_q <= ~chk_q;
                    if (chk_q)
                        count_q <= 6'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
